ex_mem_elastic_reg: RTL and testbench

Parametrised, elastic EX→MEM pipeline register, the successor to the fixed single-entry execute-stage register. It holds up to DEPTH in-flight execute results (destination, ALU result, store data, memory/write-back controls) in a ring buffer. It decouples the execute and memory stages with a valid/ready handshake. It also keeps the freeze semantics and adds a single-cycle flush for branch/hazard recovery.

---
 rtl/ex_mem_elastic_reg_pkg.sv | 29 ++
 rtl/ex_mem_elastic_reg_if.sv | 54 +++++
 rtl/ex_mem_elastic_reg_ring_ptr_ctrl.sv | 62 ++++++
 rtl/ex_mem_elastic_reg.sv | 80 ++++++++
 tb/tb_ex_mem_elastic_reg.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_elastic_reg_pkg.sv
// ============================================================================
// Module : ex_mem_pkg
// Brief  : Shared widths, entry layout and occupancy helper for the EX/MEM buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex_mem_pkg;

    localparam int C_WORD_WIDTH   = 32;
    localparam int C_REG_ADDR_LEN = 4;

    typedef struct packed {
        logic [C_REG_ADDR_LEN-1:0] dst;
        logic [C_WORD_WIDTH-1:0]   alu_res;
        logic [C_WORD_WIDTH-1:0]   val_rm;
        logic                      mem_read;
        logic                      mem_write;
        logic                      wb_en;
    } ex_mem_entry_t;

    // Counter must hold the value DEPTH itself, hence DEPTH+1 states.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_elastic_reg_if.sv
// ============================================================================
// Module : ex_mem_elastic_reg_if
// Brief  : Execute-side / memory-side handshake bundle of the EX/MEM buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ex_mem_elastic_reg_if
    import ex_mem_pkg::*;
#(
    parameter int WORD_WIDTH   = C_WORD_WIDTH,
    parameter int REG_ADDR_LEN = C_REG_ADDR_LEN,
    parameter int DEPTH        = 2
);
    localparam int CNT_W = occ_width(DEPTH);

    logic                    freeze;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [REG_ADDR_LEN-1:0] dst_in;
    logic [WORD_WIDTH-1:0]   ALU_res_in;
    logic [WORD_WIDTH-1:0]   val_Rm_in;
    logic                    mem_read_in;
    logic                    mem_write_in;
    logic                    WB_en_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [REG_ADDR_LEN-1:0] dst_out;
    logic [WORD_WIDTH-1:0]   ALU_res_out;
    logic [WORD_WIDTH-1:0]   val_Rm_out;
    logic                    mem_read_out;
    logic                    mem_write_out;
    logic                    WB_en_out;
    logic [CNT_W-1:0]        count;

    // master = surrounding pipeline, slave = the buffer itself
    modport master (
        output freeze, flush, in_valid, dst_in, ALU_res_in, val_Rm_in,
               mem_read_in, mem_write_in, WB_en_in, out_ready,
        input  in_ready, out_valid, dst_out, ALU_res_out, val_Rm_out,
               mem_read_out, mem_write_out, WB_en_out, count
    );

    modport slave (
        input  freeze, flush, in_valid, dst_in, ALU_res_in, val_Rm_in,
               mem_read_in, mem_write_in, WB_en_in, out_ready,
        output in_ready, out_valid, dst_out, ALU_res_out, val_Rm_out,
               mem_read_out, mem_write_out, WB_en_out, count
    );

endinterface

`default_nettype wire

// File: rtl/ex_mem_elastic_reg_ring_ptr_ctrl.sv
// ============================================================================
// Module : ring_ptr_ctrl
// Brief  : Read/write ring pointers and occupancy counter for a DEPTH-entry buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ring_ptr_ctrl
    import ex_mem_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = occ_width(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             flush,
    output logic      [PTR_W-1:0] rd_ptr,
    output logic      [PTR_W-1:0] wr_ptr,
    output logic      [CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (push && !pop)
                r_count <= r_count + 1'b1;
            else if (pop && !push)
                r_count <= r_count - 1'b1;
        end
    end

    assign rd_ptr = r_rd_ptr;
    assign wr_ptr = r_wr_ptr;
    assign count  = r_count;
    assign full   = (r_count == C_DEPTH);
    assign empty  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ex_mem_elastic_reg.sv
// ============================================================================
// Module : ex_mem_elastic_reg
// Brief  : Elastic EX->MEM pipeline register: DEPTH-entry ring buffer with freeze/flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_mem_elastic_reg
    import ex_mem_pkg::*;
#(
    parameter int WORD_WIDTH   = C_WORD_WIDTH,
    parameter int REG_ADDR_LEN = C_REG_ADDR_LEN,
    parameter int DEPTH        = 2
) (
    input wire logic            clk,
    input wire logic            rst,
    ex_mem_elastic_reg_if.slave bus
);

    localparam int ENTRY_W = REG_ADDR_LEN + 2 * WORD_WIDTH + 3;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = occ_width(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] w_in_entry;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic [PTR_W-1:0]   w_wr_ptr;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;

    // Readiness ignores out_ready so no combinational path crosses the buffer.
    assign w_in_ready  = ~bus.freeze & ~w_full;
    assign w_out_valid = ~bus.freeze & ~w_empty;
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    assign w_in_entry = {bus.dst_in, bus.ALU_res_in, bus.val_Rm_in,
                         bus.mem_read_in, bus.mem_write_in, bus.WB_en_in};

    ring_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push),
        .pop    (w_pop),
        .flush  (bus.flush),
        .rd_ptr (w_rd_ptr),
        .wr_ptr (w_wr_ptr),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_push && !bus.flush) begin
            r_mem[w_wr_ptr] <= w_in_entry;
        end
    end

    // Gate the whole head entry so an idle slot can never issue a store or write-back.
    assign {bus.dst_out, bus.ALU_res_out, bus.val_Rm_out,
            bus.mem_read_out, bus.mem_write_out, bus.WB_en_out} =
           w_out_valid ? r_mem[w_rd_ptr] : '0;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.count     = w_count;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_elastic_reg.sv
// ============================================================================
// Module : tb_ex_mem_elastic_reg
// Brief  : Scoreboard bench for ex_mem_elastic_reg at DEPTH 2 and DEPTH 3.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ex_mem_elastic_reg;
    import ex_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          sel       = 1'b0;   // 0: DEPTH-2 instance, 1: DEPTH-3 instance
    logic          freeze    = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    ex_mem_entry_t in_e      = '0;

    ex_mem_entry_t obs_entry;
    logic          obs_in_ready;
    logic          obs_out_valid;
    logic [1:0]    obs_count;

    ex_mem_entry_t q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            m_known  = 1'b0;

    ex_mem_elastic_reg_if #(.WORD_WIDTH(C_WORD_WIDTH), .REG_ADDR_LEN(C_REG_ADDR_LEN), .DEPTH(2)) if2 ();
    ex_mem_elastic_reg_if #(.WORD_WIDTH(C_WORD_WIDTH), .REG_ADDR_LEN(C_REG_ADDR_LEN), .DEPTH(3)) if3 ();

    assign if2.freeze       = freeze;
    assign if2.flush        = flush;
    assign if2.in_valid     = in_valid & ~sel;
    assign if2.out_ready    = out_ready;
    assign if2.dst_in       = in_e.dst;
    assign if2.ALU_res_in   = in_e.alu_res;
    assign if2.val_Rm_in    = in_e.val_rm;
    assign if2.mem_read_in  = in_e.mem_read;
    assign if2.mem_write_in = in_e.mem_write;
    assign if2.WB_en_in     = in_e.wb_en;

    assign if3.freeze       = freeze;
    assign if3.flush        = flush;
    assign if3.in_valid     = in_valid & sel;
    assign if3.out_ready    = out_ready;
    assign if3.dst_in       = in_e.dst;
    assign if3.ALU_res_in   = in_e.alu_res;
    assign if3.val_Rm_in    = in_e.val_rm;
    assign if3.mem_read_in  = in_e.mem_read;
    assign if3.mem_write_in = in_e.mem_write;
    assign if3.WB_en_in     = in_e.wb_en;

    ex_mem_elastic_reg #(.WORD_WIDTH(C_WORD_WIDTH), .REG_ADDR_LEN(C_REG_ADDR_LEN), .DEPTH(2))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    ex_mem_elastic_reg #(.WORD_WIDTH(C_WORD_WIDTH), .REG_ADDR_LEN(C_REG_ADDR_LEN), .DEPTH(3))
        u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    always_comb begin
        obs_in_ready  = sel ? if3.in_ready  : if2.in_ready;
        obs_out_valid = sel ? if3.out_valid : if2.out_valid;
        obs_count     = sel ? if3.count     : if2.count;
        obs_entry     = sel ?
            {if3.dst_out, if3.ALU_res_out, if3.val_Rm_out, if3.mem_read_out, if3.mem_write_out, if3.WB_en_out} :
            {if2.dst_out, if2.ALU_res_out, if2.val_Rm_out, if2.mem_read_out, if2.mem_write_out, if2.WB_en_out};
    end

    function automatic ex_mem_entry_t mk(input logic [3:0] dst, input logic [31:0] alu,
                                         input logic [31:0] rm, input logic mr,
                                         input logic mw, input logic wb);
        ex_mem_entry_t e;
        e.dst = dst; e.alu_res = alu; e.val_rm = rm;
        e.mem_read = mr; e.mem_write = mw; e.wb_en = wb;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check mid-cycle against the model, then advance model and DUT one edge.
    task automatic cycle();
        bit exp_ir;
        bit exp_ov;
        bit do_push;
        bit do_pop;
        int depth;
        @(negedge clk);
        depth   = sel ? 3 : 2;
        exp_ir  = !freeze && (q.size() < depth);
        exp_ov  = !freeze && (q.size() != 0);
        do_push = in_valid && exp_ir;
        do_pop  = exp_ov && out_ready;
        if (m_known) begin
            chk("in_ready", obs_in_ready, exp_ir);
            chk("out_valid", obs_out_valid, exp_ov);
            chk("count", obs_count, q.size());
            if (exp_ov)
                chk(do_pop ? "pop_entry" : "head_entry", obs_entry, q[0]);
            else
                chk("idle_outputs_zero", obs_entry, '0);
        end
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(in_e);
        end
        if (rst) m_known = 1'b1;
        #1;
    endtask

    initial begin
        // Reset held two cycles with a valid entry offered.
        rst = 1'b1; in_valid = 1'b1;
        in_e = mk(4'hF, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        cycle(); cycle();
        rst = 1'b0; in_valid = 1'b0;
        cycle();

        // Single pass.
        out_ready = 1'b1; in_valid = 1'b1;
        in_e = mk(4'h3, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();

        // Backpressure to full, then drain A, B, C.
        out_ready = 1'b0; in_valid = 1'b1;
        in_e = mk(4'hA, 32'hA0A0_0001, 32'h0000_000A, 1'b1, 1'b0, 1'b1); cycle();
        in_e = mk(4'hB, 32'hB0B0_0002, 32'h0000_000B, 1'b0, 1'b1, 1'b0); cycle();
        in_e = mk(4'hC, 32'hC0C0_0003, 32'h0000_000C, 1'b0, 1'b0, 1'b1); cycle(); cycle();
        out_ready = 1'b1;
        cycle(); cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        // Freeze with two entries buffered.
        out_ready = 1'b0; in_valid = 1'b1;
        in_e = mk(4'h1, 32'h1111_1111, 32'h0101_0101, 1'b1, 1'b0, 1'b1); cycle();
        in_e = mk(4'h2, 32'h2222_2222, 32'h0202_0202, 1'b0, 1'b1, 1'b1); cycle();
        freeze = 1'b1; out_ready = 1'b1;
        in_e = mk(4'h7, 32'h7777_7777, 32'h0707_0707, 1'b1, 1'b1, 1'b1);
        repeat (3) cycle();
        freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cycle();

        // Flush while full and popping; a pushed entry must not survive.
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle(); cycle();

        // Streaming across pointer wrap on the DEPTH-3 instance.
        sel = 1'b1; out_ready = 1'b1;
        cycle();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_e = mk(4'(i), 32'h1000_0000 + 32'(i), ~32'(i), i[0], i[1], i[2]);
            cycle();
            chk("stream_count_le1", (obs_count <= 2'd1), 1'b1);
        end
        in_valid = 1'b0;
        cycle(); cycle();

        // Flush collision with push and pop on the DEPTH-3 instance.
        out_ready = 1'b0; in_valid = 1'b1;
        in_e = mk(4'h4, 32'h4444_0004, 32'h0000_0044, 1'b0, 1'b1, 1'b1); cycle();
        in_e = mk(4'h5, 32'h5555_0005, 32'h0000_0055, 1'b1, 1'b0, 1'b1); cycle();
        flush = 1'b1; out_ready = 1'b1;
        in_e = mk(4'h6, 32'h6666_0006, 32'h0000_0066, 1'b0, 1'b1, 1'b1);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle(); cycle();

        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
